// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// cpu_run_ctrl : boots, runs, pauses, single-steps and stops the RISC-V core.
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_run_ctrl #(
    parameter int CNT_W       = 32,
    parameter int BOOT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             instr_retire,
    input  logic             halt_req,
    input  logic             dbg_halt,
    input  logic             dbg_step,
    input  logic [CNT_W-1:0] cycle_limit,
    output logic             cpu_en,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BOOT    = 3'd1,
        S_RUN     = 3'd2,
        S_PAUSED  = 3'd3,
        S_STEP    = 3'd4,
        S_HALTED  = 3'd5,
        S_TIMEOUT = 3'd6
    } state_t;

    localparam int              BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0]   BOOT_LAST = BW'(BOOT_CYCLES - 1);
    localparam logic [BW-1:0]   BOOT_ONE  = BW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t          cur_state;
    state_t          nxt_state;
    logic [BW-1:0]   boot_cnt;
    logic            counting;
    logic            limit_hit;
    logic            halt_now;
    logic            restart;

    assign counting  = (cur_state == S_RUN) || (cur_state == S_STEP);
    // Compare against limit-1 so cycle_cnt equals the limit once TIMEOUT is entered.
    assign limit_hit = counting && (cycle_limit != '0) && (cycle_cnt == cycle_limit - CNT_ONE);
    assign halt_now  = instr_retire && halt_req;
    assign restart   = start && ((cur_state == S_IDLE) || (cur_state == S_HALTED) ||
                                 (cur_state == S_TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state   <= S_IDLE;
            boot_cnt    <= '0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cur_state <= nxt_state;
            if (restart) begin
                boot_cnt    <= '0;
                cycle_cnt   <= '0;
                instret_cnt <= '0;
            end else begin
                if (cur_state == S_BOOT && boot_cnt != BOOT_LAST)
                    boot_cnt <= boot_cnt + BOOT_ONE;
                if (counting) begin
                    if (cycle_cnt != '1)
                        cycle_cnt <= cycle_cnt + CNT_ONE;
                    if (instr_retire && instret_cnt != '1)
                        instret_cnt <= instret_cnt + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE:    if (start) nxt_state = S_BOOT;
            S_BOOT:    if (boot_cnt == BOOT_LAST) nxt_state = S_RUN;
            S_RUN: begin
                if (halt_now)       nxt_state = S_HALTED;
                else if (limit_hit) nxt_state = S_TIMEOUT;
                else if (dbg_halt)  nxt_state = S_PAUSED;
            end
            S_PAUSED: begin
                if (!dbg_halt)     nxt_state = S_RUN;
                else if (dbg_step) nxt_state = S_STEP;
            end
            S_STEP: begin
                if (halt_now)          nxt_state = S_HALTED;
                else if (limit_hit)    nxt_state = S_TIMEOUT;
                else if (instr_retire) nxt_state = S_PAUSED;
            end
            S_HALTED:  if (start) nxt_state = S_BOOT;
            S_TIMEOUT: if (start) nxt_state = S_BOOT;
            default:   nxt_state = S_IDLE;
        endcase
    end

    assign cpu_en   = counting;
    assign core_rst = (cur_state == S_IDLE) || (cur_state == S_BOOT);
    assign running  = counting;
    assign done     = (cur_state == S_HALTED) || (cur_state == S_TIMEOUT);
    assign timeout  = (cur_state == S_TIMEOUT);
    assign state    = cur_state;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ============================================================================
// tb_cpu_run_ctrl : scoreboard bench for the run controller.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cpu_run_ctrl;

    localparam int CNT_W       = 32;
    localparam int BOOT_CYCLES = 2;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_BOOT = 3'd1, ST_RUN = 3'd2, ST_PAUSED = 3'd3,
                           ST_STEP = 3'd4, ST_HALTED = 3'd5, ST_TIMEOUT = 3'd6;

    logic             clk = 1'b0;
    logic             rst_n, start, instr_retire, halt_req, dbg_halt, dbg_step;
    logic [CNT_W-1:0] cycle_limit;
    logic             cpu_en, core_rst, running, done, timeout;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;
    logic [2:0]       state;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [31:0] cyc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cpu_run_ctrl #(.CNT_W(CNT_W), .BOOT_CYCLES(BOOT_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr_retire(instr_retire),
        .halt_req(halt_req), .dbg_halt(dbg_halt), .dbg_step(dbg_step),
        .cycle_limit(cycle_limit), .cpu_en(cpu_en), .core_rst(core_rst),
        .running(running), .done(done), .timeout(timeout), .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt), .state(state)
    );

    task automatic chk_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] st,
                            input logic [31:0] cyc, input logic [31:0] ins);
        exp_t e;
        e.tag = tag; e.st = st; e.cyc = cyc; e.ins = ins;
        sb.push_back(e);
    endtask

    // Pops the oldest expectation and checks state, decoded flags and counters.
    task automatic pop_cmp();
        exp_t e;
        logic ex_en, ex_rst, ex_done, ex_to;
        if (sb.size() == 0) begin
            chk_value("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e       = sb.pop_front();
        ex_en   = (e.st == ST_RUN) || (e.st == ST_STEP);
        ex_rst  = (e.st == ST_IDLE) || (e.st == ST_BOOT);
        ex_done = (e.st == ST_HALTED) || (e.st == ST_TIMEOUT);
        ex_to   = (e.st == ST_TIMEOUT);
        chk_value({e.tag, ".state"}, {29'd0, state}, {29'd0, e.st});
        chk_value({e.tag, ".flags"}, {27'd0, cpu_en, core_rst, running, done, timeout},
                  {27'd0, ex_en, ex_rst, ex_en, ex_done, ex_to});
        chk_value({e.tag, ".cycle_cnt"}, cycle_cnt, e.cyc);
        chk_value({e.tag, ".instret_cnt"}, instret_cnt, e.ins);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pulses start and walks through the boot window into RUN.
    task automatic launch(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        push_exp({tag, ".boot"}, ST_BOOT, 32'd0, 32'd0);
        pop_cmp();
        ticks(BOOT_CYCLES);
        push_exp({tag, ".run"}, ST_RUN, 32'd0, 32'd0);
        pop_cmp();
    endtask

    task automatic wait_done(input string tag, input int budget, input int exp_cycles);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk_value({tag, ".cycles_to_done"}, n, exp_cycles);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; instr_retire = 1'b0; halt_req = 1'b0;
        dbg_halt = 1'b0; dbg_step = 1'b0; cycle_limit = '0;
        ticks(2);
        push_exp("reset", ST_IDLE, 32'd0, 32'd0);
        pop_cmp();
        rst_n = 1'b1;
        ticks(2);
        push_exp("idle_hold", ST_IDLE, 32'd0, 32'd0);
        pop_cmp();

        // Boot window then halt on the 10th retire.
        start = 1'b1;
        tick();
        start = 1'b0;
        push_exp("boot1", ST_BOOT, 32'd0, 32'd0);
        pop_cmp();
        tick();
        push_exp("boot2", ST_BOOT, 32'd0, 32'd0);
        pop_cmp();
        tick();
        push_exp("run_entry", ST_RUN, 32'd0, 32'd0);
        pop_cmp();
        instr_retire = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            halt_req = (i == 10);
            start    = (i == 5);
            tick();
        end
        instr_retire = 1'b0; halt_req = 1'b0; start = 1'b0;
        push_exp("halt10", ST_HALTED, 32'd10, 32'd10);
        pop_cmp();
        ticks(3);
        push_exp("halt_sticky", ST_HALTED, 32'd10, 32'd10);
        pop_cmp();
        launch("restart");

        // Cycle limit 25 from a restart out of HALTED.
        instr_retire = 1'b0;
        cycle_limit  = 32'd25;
        wait_done("limit25", 200, 25);
        push_exp("limit25", ST_TIMEOUT, 32'd25, 32'd0);
        pop_cmp();

        // Cycle limit 1: exactly one RUN cycle.
        cycle_limit = 32'd1;
        launch("lim1");
        tick();
        push_exp("limit1", ST_TIMEOUT, 32'd1, 32'd0);
        pop_cmp();

        // Pause after 4 counted cycles, hold, then a 3-cycle single step.
        cycle_limit = '0;
        launch("dbg");
        ticks(3);
        dbg_halt = 1'b1;
        tick();
        push_exp("pause_entry", ST_PAUSED, 32'd4, 32'd0);
        pop_cmp();
        ticks(6);
        push_exp("pause_hold", ST_PAUSED, 32'd4, 32'd0);
        pop_cmp();
        dbg_step = 1'b1;
        tick();
        dbg_step = 1'b0;
        push_exp("step_entry", ST_STEP, 32'd4, 32'd0);
        pop_cmp();
        ticks(2);
        push_exp("step_wait", ST_STEP, 32'd6, 32'd0);
        pop_cmp();
        instr_retire = 1'b1;
        tick();
        instr_retire = 1'b0;
        push_exp("step_done", ST_PAUSED, 32'd7, 32'd1);
        pop_cmp();
        dbg_halt = 1'b0;
        tick();
        push_exp("resume", ST_RUN, 32'd7, 32'd1);
        pop_cmp();
        tick();
        push_exp("resume_cnt", ST_RUN, 32'd8, 32'd1);
        pop_cmp();
        instr_retire = 1'b1; halt_req = 1'b1;
        tick();
        instr_retire = 1'b0; halt_req = 1'b0;
        push_exp("dbg_halt_end", ST_HALTED, 32'd9, 32'd2);
        pop_cmp();

        // Halt and limit hit together: halt wins.
        cycle_limit = 32'd7;
        launch("tie");
        ticks(6);
        instr_retire = 1'b1; halt_req = 1'b1;
        tick();
        instr_retire = 1'b0; halt_req = 1'b0;
        push_exp("halt_vs_limit", ST_HALTED, 32'd7, 32'd1);
        pop_cmp();

        // Limit hit and dbg_halt together: timeout wins.
        cycle_limit = 32'd3;
        launch("tie2");
        ticks(2);
        dbg_halt = 1'b1;
        tick();
        dbg_halt = 1'b0;
        push_exp("limit_vs_dbg", ST_TIMEOUT, 32'd3, 32'd0);
        pop_cmp();

        // Reset mid-run with 100 counted cycles.
        cycle_limit = '0;
        launch("rst");
        ticks(100);
        push_exp("pre_reset", ST_RUN, 32'd100, 32'd0);
        pop_cmp();
        rst_n = 1'b0; start = 1'b1;
        tick();
        push_exp("mid_reset", ST_IDLE, 32'd0, 32'd0);
        pop_cmp();
        tick();
        push_exp("reset_start_ignored", ST_IDLE, 32'd0, 32'd0);
        pop_cmp();
        rst_n = 1'b1; start = 1'b0;
        tick();
        push_exp("post_reset", ST_IDLE, 32'd0, 32'd0);
        pop_cmp();

        chk_value("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the RISC-V core. It sequences a program run: it holds the core in reset through a boot window, then enables execution, counts cycles and retired instructions, and stops on an EBREAK halt, a cycle-limit timeout, or a debug pause. It also supports single-step. It sits between the board-level start/debug inputs and the core's enable and reset inputs, and replaces free-running cycle counting with a controlled, bounded run.

## Interface
- CNT_W, 32: width of cycle and instret counters and of cycle_limit
- BOOT_CYCLES, 2: cycles core_rst is held after start (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin/restart run; sampled only in IDLE, HALTED, TIMEOUT
- instr_retire  in  1  core retires an instruction this cycle (valid only while cpu_en=1)
- halt_req  in  1  retiring instruction is EBREAK; qualified by instr_retire
- dbg_halt  in  1  level; request pause
- dbg_step  in  1  pulse; execute one instruction while paused
- cycle_limit  in  CNT_W  max run cycles; 0 = unlimited
- cpu_en  out  1  core advances PC/writes state when 1
- core_rst  out  1  active-high reset to core datapath
- running  out  1  state is RUN or STEP
- done  out  1  state is HALTED or TIMEOUT
- timeout  out  1  state is TIMEOUT
- cycle_cnt  out  CNT_W  cycles with cpu_en=1 since last start
- instret_cnt  out  CNT_W  retired instructions since last start
- state  out  3  IDLE=0, BOOT=1, RUN=2, PAUSED=3, STEP=4, HALTED=5, TIMEOUT=6

## Operation
- Reset (rst_n=0 at edge): state=IDLE, counters=0, boot counter=0. Outputs during reset: cpu_en=0, core_rst=1, running=0, done=0, timeout=0.
- All outputs except the counters are decoded from the registered state (Moore).
- core_rst=1 in IDLE and BOOT, and 0 otherwise. cpu_en=1 only in RUN and STEP.
- IDLE: when start=1, go to BOOT. cycle_cnt, instr_cnt and the boot counter clear to 0.
- BOOT: the boot counter increments each cycle. When it reaches BOOT_CYCLES-1, go to RUN.
- RUN:
  - cycle_cnt increments each cycle.
  - instret_cnt increments when instr_retire=1.
  - Next-state priority: halt_req&instr_retire → HALTED; otherwise limit hit → TIMEOUT; otherwise dbg_halt → PAUSED.
- Limit hit: cycle_limit≠0 and cycle_cnt==cycle_limit-1 in a counting cycle. cycle_cnt then equals cycle_limit on entry to TIMEOUT.
- PAUSED:
  - Counters hold.
  - dbg_halt=0 → RUN. Otherwise, dbg_step=1 → STEP.
  - dbg_step is ignored when dbg_halt=0.
- STEP:
  - Counting is the same as in RUN.
  - Next-state priority: halt_req&instr_retire → HALTED; otherwise limit hit → TIMEOUT; otherwise instr_retire → PAUSED.
  - Remain in STEP until the instruction retires.
- HALTED / TIMEOUT: counters hold; sticky. start=1 → BOOT with counters cleared (restart).
- start is ignored in BOOT, RUN, PAUSED and STEP.
- Counters saturate at all-ones and never wrap. Saturation is only reachable when cycle_limit=0.
- The instruction that raises halt_req is counted in instret_cnt, and its cycle is counted in cycle_cnt.
- Reset mid-run (any state): at the next edge, return to IDLE with counters at 0. There are no partial effects.

## Timing
- start high at edge k (state IDLE): state=BOOT from k+1 through k+BOOT_CYCLES. state=RUN and cpu_en=1 from k+BOOT_CYCLES+1.
- Halt: instr_retire&halt_req high at edge h in RUN. cpu_en=0 and done=1 from h+1; no extra cycles execute.
- dbg_halt sampled at edge p in RUN: cycle p still counts, and cpu_en=0 from p+1.
- Pause exit: dbg_halt low at edge r in PAUSED gives cpu_en=1 from r+1.
- Step: dbg_step at edge s gives cpu_en=1 from s+1 until the edge at which instr_retire=1; the state returns to PAUSED one cycle later.
- Boundary cases:
  - cycle_limit=1: exactly one RUN cycle, then TIMEOUT.
  - Halt and limit hit in the same cycle: the result is HALTED, not TIMEOUT.
  - Limit hit and dbg_halt in the same cycle: the result is TIMEOUT.
- Changing cycle_limit mid-run takes effect immediately.
  - If the new value is ≤ cycle_cnt, no compare match occurs and the run continues until halt or saturation.
  - Software must set the limit before start.

## Test plan
- Reset with BOOT_CYCLES=2 and start pulse at edge 5 → state BOOT on edges 6–7; RUN with cpu_en=1 at edge 8; core_rst=1 until edge 7 inclusive.
- RUN with instr_retire every cycle and halt_req on the 10th retire → HALTED, cycle_cnt=10, instret_cnt=10, done=1, cpu_en=0; then start → BOOT with counters 0.
- cycle_limit=25 and no halt → TIMEOUT with cycle_cnt=25, timeout=1, done=1. A second bench with cycle_limit=1 → one RUN cycle, cycle_cnt=1.
- dbg_halt asserted after 4 RUN cycles, held 6 cycles, then dbg_step with retire delayed 3 cycles → cycle_cnt goes 4→4 (held), then +3 in STEP, instret_cnt+1, state back to PAUSED; releasing dbg_halt returns to RUN.
- Simultaneous halt_req&instr_retire and limit hit (cycle_limit=7, halt on cycle 7) → HALTED, timeout=0, cycle_cnt=7.
- rst_n pulled low mid-RUN with cycle_cnt=100 → next edge state=IDLE, counters 0, core_rst=1, cpu_en=0; start is ignored while rst_n=0.
